// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by both ends of the serial link (RX and TX).
// Holds default clock/baud figures, the frame data width and the receiver
// state encoding so that both sides agree on framing.
package uart_pkg;

    localparam int unsigned F_IN_DEFAULT  = 50_000_000;
    localparam int unsigned F_OUT_DEFAULT = 115_200;
    localparam int unsigned DATA_BITS     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
// Ports:
//   in_clk - destination clock
//   nrst   - asynchronous active-low reset (both flops load RST_VAL)
//   d      - asynchronous input
//   q      - synchronized output, two cycles after d
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic in_clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge in_clk or negedge nrst) begin
        if (!nrst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver running on the system clock.
// The bit-phase counter is realigned on every start edge; bits are sampled
// at mid-bit and each good byte is presented with a one-cycle strobe.
// Ports:
//   in_clk    - system clock
//   nrst      - asynchronous active-low reset
//   rx        - serial line (asynchronous, idles high)
//   data      - last correctly received byte, held until the next good frame
//   valid     - one-cycle pulse, data is new this cycle
//   frame_err - one-cycle pulse, stop bit sampled low
//   busy      - high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned F_IN  = F_IN_DEFAULT,
    parameter int unsigned F_OUT = F_OUT_DEFAULT,
    parameter int unsigned T     = F_IN / F_OUT,
    parameter int unsigned HALF  = T / 2,
    parameter int unsigned CW    = $clog2(T)
) (
    input  logic       in_clk,
    input  logic       nrst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned     IW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0]   HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(T - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .in_clk (in_clk),
        .nrst   (nrst),
        .d      (rx),
        .q      (rx_s)
    );

    always_ff @(posedge in_clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IW'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data  <= shift;
                            valid <= 1'b1;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line so it cannot retrigger frames.
                    if (rx_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BIT_T  = 434;
    localparam int HALF_T = 217;
    // Pad edge driven at cycle s -> rx_s low in cycle s+2 (= d); strobe at d+4124.
    localparam int STROBE_LAT = 2 + HALF_T + 9 * BIT_T + 1;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [7:0] last_good;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    uart_rx #(.F_IN(50_000_000), .F_OUT(115_200)) dut (
        .in_clk    (clk),
        .nrst      (nrst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (nrst && (valid || frame_err)) begin
                check("strobe_exclusive", {31'd0, valid && frame_err}, 0);
                check("strobe_expected", {31'd0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
                    check("strobe_data", {24'd0, data}, {24'd0, e.data});
                    check("strobe_cycle", cyc, e.cyc);
                end
                if (valid) n_valid++;
                if (frame_err) n_err++;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int period, input logic stop);
        exp_t e;
        if (stop) begin
            last_good = b;
            e.data = b;
            e.err  = 1'b0;
        end else begin
            e.data = last_good;
            e.err  = 1'b1;
        end
        e.cyc = cyc + STROBE_LAT;
        sb.push_back(e);
        rx = 1'b0;
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (period) @(negedge clk);
        end
        rx = stop;
        repeat (period) @(negedge clk);
    endtask

    initial begin
        int s;
        logic [7:0] abort_byte;
        nrst = 1'b0;
        rx = 1'b1;
        last_good = 8'h00;
        fork
            monitor();
        join_none
        repeat (5) @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(negedge clk);

        check("reset_data", {24'd0, data}, 0);
        check("reset_valid", {31'd0, valid}, 0);
        check("reset_frame_err", {31'd0, frame_err}, 0);
        check("reset_busy", {31'd0, busy}, 0);

        // Nominal frame
        send_frame(8'hA5, BIT_T, 1'b1);
        rx = 1'b1;
        repeat (500) @(negedge clk);
        check("a5_held", {24'd0, data}, 32'hA5);

        // Short low pulse: rejected at the start-bit sample
        s = cyc;
        rx = 1'b0;
        wait_until(s + 2);
        check("glitch_busy_d", {31'd0, busy}, 0);
        wait_until(s + 3);
        check("glitch_busy_rise", {31'd0, busy}, 1);
        wait_until(s + 100);
        rx = 1'b1;
        wait_until(s + 2 + HALF_T);
        check("glitch_busy_sample", {31'd0, busy}, 1);
        wait_until(s + 3 + HALF_T);
        check("glitch_busy_fall", {31'd0, busy}, 0);
        repeat (300) @(negedge clk);

        // Bad stop bit followed by a long low hold
        send_frame(8'h3C, BIT_T, 1'b0);
        repeat (2000) @(negedge clk);
        check("break_data", {24'd0, data}, 32'hA5);
        s = cyc;
        check("break_busy_hold", {31'd0, busy}, 1);
        rx = 1'b1;
        wait_until(s + 2);
        check("break_busy_sync", {31'd0, busy}, 1);
        wait_until(s + 3);
        check("break_busy_fall", {31'd0, busy}, 0);
        repeat (500) @(negedge clk);

        // Back-to-back frames
        send_frame(8'h00, BIT_T, 1'b1);
        send_frame(8'hFF, BIT_T, 1'b1);
        rx = 1'b1;
        repeat (500) @(negedge clk);
        check("b2b_data", {24'd0, data}, 32'hFF);

        // Reset during data bit 4
        abort_byte = 8'hC3;
        rx = 1'b0;
        repeat (BIT_T) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            repeat (BIT_T) @(negedge clk);
        end
        rx = abort_byte[4];
        repeat (HALF_T) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("abort_data", {24'd0, data}, 0);
        check("abort_valid", {31'd0, valid}, 0);
        check("abort_frame_err", {31'd0, frame_err}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        last_good = 8'h00;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle_busy", {31'd0, busy}, 0);
        send_frame(8'h5A, BIT_T, 1'b1);
        rx = 1'b1;
        repeat (500) @(negedge clk);

        // Transmitter clock off by about +/-2%
        send_frame(8'h81, 425, 1'b1);
        rx = 1'b1;
        repeat (500) @(negedge clk);
        send_frame(8'h81, 443, 1'b1);
        rx = 1'b1;
        repeat (500) @(negedge clk);

        for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("valid_count", n_valid, 6);
        check("frame_err_count", n_err, 1);
        check("final_data", {24'd0, data}, 32'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
